// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause
// codes, counter sizing and the cause priority ranking.
package rstseq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_EXT = 2'b01,
        CAUSE_SW  = 2'b10,
        CAUSE_WDT = 2'b11
    } cause_e;

    // Bits needed to hold the largest of three terminal counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    // Higher value wins: POR > WDT > EXT > SW.
    function automatic logic [1:0] cause_prio(input cause_e c);
        logic [1:0] p;
        case (c)
            CAUSE_POR: p = 2'd3;
            CAUSE_WDT: p = 2'd2;
            CAUSE_EXT: p = 2'd1;
            default:   p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// Synchroniser plus saturating debounce counter for an asynchronous level input.
// Request rises after DEBOUNCE consecutive synchronised-high edges, drops at once.
module rst_debounce
    import rstseq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 8,
    parameter int CW          = cnt_width(1, 1, DEBOUNCE)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic req_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        cnt_d  = cnt_q;
        req_d  = req_q;
        if (!level) begin
            cnt_d = '0;
            req_d = 1'b0;
        end else if (cnt_q != CW'(DEBOUNCE)) begin
            cnt_d = cnt_q + CW'(1);
            req_d = (cnt_q == CW'(DEBOUNCE - 1));
        end else begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            req_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/rstseq.sv
// Reset sequencer: asserts NCH reset channels together on any request, then
// releases them in ascending order after HOLD cycles, GAP cycles apart.
module rstseq
    import rstseq_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int HOLD        = 16,
    parameter int GAP         = 4,
    parameter int DEBOUNCE    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           CLK_I,
    input  logic           RESET_I,
    input  logic           EXT_RST_I,
    input  logic           SW_RST_I,
    input  logic           WDT_RST_I,
    output logic [NCH-1:0] RESET_O,
    output logic [NCH-1:0] RESET_N_O,
    output logic           READY_O,
    output logic [1:0]     CAUSE_O
);

    localparam int CW  = cnt_width(HOLD, GAP, DEBOUNCE);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic [NCH-1:0] rst_q, rst_d;
    logic [NCH-1:0] rst_n_q, rst_n_d;
    logic           ready_q, ready_d;
    cause_e         cause_q, cause_d;

    logic           ext_req;
    logic           req;
    logic           release0;
    cause_e         top_cause;

    rst_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE),
        .CW          (CW)
    ) u_ext_db (
        .clk_i   (CLK_I),
        .rst_i   (RESET_I),
        .async_i (EXT_RST_I),
        .req_o   (ext_req)
    );

    assign req = RESET_I | WDT_RST_I | ext_req | SW_RST_I;

    always_comb begin
        top_cause = CAUSE_SW;
        if (WDT_RST_I)    top_cause = CAUSE_WDT;
        else if (ext_req) top_cause = CAUSE_EXT;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chan_d   = chan_q;
        rst_d    = rst_q;
        ready_d  = ready_q;
        cause_d  = cause_q;
        release0 = 1'b0;

        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            chan_d  = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (RESET_I)
                cause_d = CAUSE_POR;
            else if (state_q != ST_ASSERT ||
                     cause_prio(top_cause) > cause_prio(cause_q))
                cause_d = top_cause;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (HOLD == 1) begin
                        release0 = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CW'(HOLD - 1)) release0 = 1'b1;
                    else                        cnt_d    = cnt_q + CW'(1);
                end
                ST_RELEASE: begin
                    if (cnt_q == CW'(GAP)) begin
                        rst_d[chan_q] = 1'b0;
                        cnt_d         = CW'(1);
                        if (chan_q == CHW'(NCH - 1)) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            chan_d = chan_q + CHW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_ASSERT;
            endcase

            // Channel 0 leaves reset; with one channel that also ends the sequence.
            if (release0) begin
                rst_d[0] = 1'b0;
                cnt_d    = CW'(1);
                if (NCH == 1) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_RELEASE;
                    chan_d  = CHW'(1);
                end
            end
        end

        rst_n_d = ~rst_d;
    end

    always_ff @(posedge CLK_I) begin
        if (RESET_I) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            chan_q  <= '0;
            rst_q   <= '1;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            rst_q   <= rst_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign RESET_O   = rst_q;
    assign RESET_N_O = rst_n_q;
    assign READY_O   = ready_q;
    assign CAUSE_O   = cause_q;

endmodule

// File: tb/tb_rstseq.sv
// Bench for rstseq: three parameterisations driven by shared stimulus, each
// checked every cycle against a release-time model kept in the bench.
module tb_rstseq;

    localparam int NI = 3;
    localparam int P_NCH  [NI] = '{3, 1, 8};
    localparam int P_HOLD [NI] = '{16, 1, 5};
    localparam int P_GAP  [NI] = '{4, 1, 3};
    localparam int P_DEB  [NI] = '{8, 1, 3};
    localparam int P_SYNC [NI] = '{2, 2, 3};
    localparam int W = 19;   // {rst_n[7:0], cause[1:0], ready, rst[7:0]}

    logic clk;
    logic reset_i, ext_rst, sw_rst, wdt_rst;

    logic [2:0] rst0, rstn0;
    logic       rdy0;
    logic [1:0] cause0;
    logic [0:0] rst1, rstn1;
    logic       rdy1;
    logic [1:0] cause1;
    logic [7:0] rst2, rstn2;
    logic       rdy2;
    logic [1:0] cause2;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    logic         ext_hist[$];
    int           quiet_n [NI];
    logic [1:0]   cause_m [NI];
    int           checks;
    int           errors;
    int           cyc;

    rstseq #(.NCH(3), .HOLD(16), .GAP(4), .DEBOUNCE(8), .SYNC_STAGES(2)) u_dut0 (
        .CLK_I(clk), .RESET_I(reset_i), .EXT_RST_I(ext_rst), .SW_RST_I(sw_rst),
        .WDT_RST_I(wdt_rst), .RESET_O(rst0), .RESET_N_O(rstn0), .READY_O(rdy0),
        .CAUSE_O(cause0)
    );

    rstseq #(.NCH(1), .HOLD(1), .GAP(1), .DEBOUNCE(1), .SYNC_STAGES(2)) u_dut1 (
        .CLK_I(clk), .RESET_I(reset_i), .EXT_RST_I(ext_rst), .SW_RST_I(sw_rst),
        .WDT_RST_I(wdt_rst), .RESET_O(rst1), .RESET_N_O(rstn1), .READY_O(rdy1),
        .CAUSE_O(cause1)
    );

    rstseq #(.NCH(8), .HOLD(5), .GAP(3), .DEBOUNCE(3), .SYNC_STAGES(3)) u_dut2 (
        .CLK_I(clk), .RESET_I(reset_i), .EXT_RST_I(ext_rst), .SW_RST_I(sw_rst),
        .WDT_RST_I(wdt_rst), .RESET_O(rst2), .RESET_N_O(rstn2), .READY_O(rdy2),
        .CAUSE_O(cause2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    function automatic logic [1:0] m_prio(input logic [1:0] c);
        case (c)
            2'b00:   return 2'd3;
            2'b11:   return 2'd2;
            2'b01:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Debounced request seen at this edge: the raw input sampled high on the D
    // edges ending S+1 edges ago.
    function automatic logic ext_window(input int s, input int d);
        int t;
        t = ext_hist.size();
        if (t - s - d < 0) return 1'b0;
        for (int j = t - s - d; j < t - s; j++)
            if (!ext_hist[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic s, input logic w);
        logic         xr, req, rel, rdy;
        logic [1:0]   top;
        logic [7:0]   er, ern;
        logic [W-1:0] ex;
        for (int i = 0; i < NI; i++) begin
            xr  = ext_window(P_SYNC[i], P_DEB[i]);
            req = r | w | xr | s;
            top = r ? 2'b00 : w ? 2'b11 : xr ? 2'b01 : 2'b10;
            if (r)
                cause_m[i] = 2'b00;
            else if (req && (quiet_n[i] != 0 || m_prio(top) > m_prio(cause_m[i])))
                cause_m[i] = top;
            if (req)                   quiet_n[i] = 0;
            else if (quiet_n[i] < 1000) quiet_n[i] = quiet_n[i] + 1;
            er  = '0;
            ern = '0;
            for (int k = 0; k < P_NCH[i]; k++) begin
                rel    = (quiet_n[i] >= P_HOLD[i] + k * P_GAP[i]);
                er[k]  = !rel;
                ern[k] = rel;
            end
            rdy = (quiet_n[i] >= P_HOLD[i] + (P_NCH[i] - 1) * P_GAP[i]);
            ex  = {ern, cause_m[i], rdy, er};
            case (i)
                0:       exp_q0.push_back(ex);
                1:       exp_q1.push_back(ex);
                default: exp_q2.push_back(ex);
            endcase
        end
        ext_hist.push_back(e & ~r);
    endtask

    // Driver tasks
    task automatic drive(input logic r, input logic e, input logic s, input logic w,
                         input int n);
        for (int c = 0; c < n; c++) begin
            reset_i = r;
            ext_rst = e;
            sw_rst  = s;
            wdt_rst = w;
            @(posedge clk);
            model_step(r, e, s, w);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0, n);
    endtask

    // Scoreboard
    task automatic check(input int idx, input logic [W-1:0] act);
        logic [W-1:0] ex;
        int           sz;
        case (idx)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        if (sz == 0) return;
        case (idx)
            0:       ex = exp_q0.pop_front();
            1:       ex = exp_q1.pop_front();
            default: ex = exp_q2.pop_front();
        endcase
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL dut%0d cycle %0d got rstn=%b cause=%b ready=%b rst=%b exp rstn=%b cause=%b ready=%b rst=%b",
                     idx, cyc, act[18:11], act[10:9], act[8], act[7:0],
                     ex[18:11], ex[10:9], ex[8], ex[7:0]);
        end
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        check(0, {5'b0, rstn0, cause0, rdy0, 5'b0, rst0});
        check(1, {7'b0, rstn1, cause1, rdy1, 7'b0, rst1});
        check(2, {rstn2, cause2, rdy2, rst2});
    end

    // Stimulus
    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_i = 1'b1;
        ext_rst = 1'b0;
        sw_rst  = 1'b0;
        wdt_rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            quiet_n[i] = 0;
            cause_m[i] = 2'b00;
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 5);          // power-on reset
        idle(30);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);          // software pulse
        idle(30);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5);          // short button burst
        idle(20);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 50);         // held button
        idle(40);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        idle(17);                                  // only channel 0 released
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);          // watchdog mid-release
        idle(30);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1);          // SW and WDT together
        idle(30);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2);          // global with SW
        idle(30);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2);          // EXT arrives under SW
        drive(1'b0, 1'b1, 1'b1, 1'b0, 20);
        idle(40);

        for (int b = 0; b < 40; b++) begin
            int kind, len;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, 20);
            case (kind)
                0: drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(1, 3));
                1: drive(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(1, 3));
                2: drive(1'b0, 1'b1, 1'b0, 1'b0, len);
                3: drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len);
                default: drive(1'b0, 1'b0, 1'b1, 1'b1, 1);
            endcase
            idle($urandom_range(0, 40));
        end

        idle(20);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        idle(30);

        @(negedge clk);
        checks++;
        if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q0.size() + exp_q1.size() + exp_q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
